// File: rtl/inv_round_col_seq_if.sv
// Bundle of the sequencer's data/handshake signals.
//   upstream   : in_valid, in_ready, state_in, round_key, skip_mix
//   mix unit   : mx_col_out (to unit data_in), mx_col_in (from unit data_out)
//   downstream : out_valid, out_ready, state_out
//   status     : busy
// slave  = the sequencer itself; master = the environment around it.
interface inv_round_col_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic [31:0]  mx_col_out;
    logic [31:0]  mx_col_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport slave (
        input  in_valid, state_in, round_key, skip_mix, mx_col_in, out_ready,
        output in_ready, mx_col_out, out_valid, state_out, busy
    );

    modport master (
        output in_valid, state_in, round_key, skip_mix, mx_col_in, out_ready,
        input  in_ready, mx_col_out, out_valid, state_out, busy
    );
endinterface

// File: rtl/inv_round_col_seq.sv
// Inverse-cipher round sequencer feeding a 32-bit column InvMixColumns unit.
// Performs AddRoundKey on a 128-bit state, streams the four columns out one
// per cycle, collects the results MX_LATENCY cycles later and presents the
// reassembled state with a valid/ready handshake. skip_mix bypasses the unit.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - inv_round_col_seq_if.slave (upstream, mix unit, downstream, busy)
module inv_round_col_seq #(
    parameter int unsigned MX_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_round_col_seq_if.slave    bus
);
    localparam int unsigned COL_W   = 32;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                 state;
    logic [STATE_W-1:0]     ark;
    logic [CNT_W-1:0]       feed_cnt;
    logic [CNT_W-1:0]       cap_cnt;
    logic [MX_LATENCY-1:0]  cap_pipe;
    logic [STATE_W-1:0]     ark_in;
    logic                   cap_fire;

    logic                   in_ready;
    logic                   out_valid;
    logic                   busy;
    logic [COL_W-1:0]       mx_col_out;
    logic [STATE_W-1:0]     state_out;

    // Column 0 occupies the most significant word.
    function automatic logic [COL_W-1:0] col_sel(input logic [STATE_W-1:0] s,
                                                 input logic [CNT_W-1:0] idx);
        logic [COL_W-1:0] c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic logic [STATE_W-1:0] col_put(input logic [STATE_W-1:0] s,
                                                   input logic [CNT_W-1:0] idx,
                                                   input logic [COL_W-1:0] c);
        logic [STATE_W-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

    assign ark_in = bus.state_in ^ bus.round_key;

    // cap_pipe tracks which cycles carried a fed column; its oldest bit marks
    // the edge on which that column's result sits on mx_col_in.
    assign cap_fire = cap_pipe[MX_LATENCY-1] && ((state == FEED) || (state == DRAIN));

    // Sequencer state, counters, capture pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ark        <= '0;
            feed_cnt   <= '0;
            cap_cnt    <= '0;
            cap_pipe   <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            mx_col_out <= '0;
            state_out  <= '0;
        end else begin
            cap_pipe <= MX_LATENCY'({cap_pipe, (state == FEED)});

            if (cap_fire) begin
                state_out <= col_put(state_out, cap_cnt, bus.mx_col_in);
                cap_cnt   <= cap_cnt + 2'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ark      <= ark_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (bus.skip_mix) begin
                            state     <= DONE;
                            state_out <= ark_in;
                            out_valid <= 1'b1;
                        end else begin
                            state      <= FEED;
                            feed_cnt   <= '0;
                            cap_cnt    <= '0;
                            mx_col_out <= col_sel(ark_in, 2'd0);
                        end
                    end
                end
                FEED: begin
                    feed_cnt <= feed_cnt + 2'd1;
                    if (feed_cnt == 2'd3) begin
                        state      <= DRAIN;
                        mx_col_out <= '0;
                    end else begin
                        mx_col_out <= col_sel(ark, feed_cnt + 2'd1);
                    end
                end
                DRAIN: begin
                    if (cap_fire && (cap_cnt == 2'd3)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.mx_col_out = mx_col_out;
    assign bus.state_out  = state_out;
endmodule
